// File: rtl/coeff_table_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port VLC/coefficient ROM between decoders, with lock support.
// Latency: grant and ROM request are combinational in the issue cycle; Data_Valid_O follows READ_LATENCY cycles later.
// Backpressure: a requester not granted stalls (must hold request and address); a lock stalls all non-owners.
module coeff_table_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,   // legal range 1..4
    parameter int LOCK_MAX     = 64
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        Req_En_I,
    input  logic [NUM_REQ*ADDR_W-1:0] Req_Addr_I,
    input  logic [NUM_REQ-1:0]        Lock_I,
    output logic [NUM_REQ-1:0]        Grant_O,
    output logic [NUM_REQ-1:0]        Data_Valid_O,
    output logic [DATA_W-1:0]         Data_O,
    output logic                      Lock_Timeout_O,
    output logic                      Table_En_O,
    output logic [ADDR_W-1:0]         Table_Addr_O,
    input  logic [DATA_W-1:0]         Table_Data_I
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e          state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic [CNT_W-1:0]     lock_cnt_q;
    logic                 timeout_q;
    // Set for a requester whose lock was forcibly released; cleared once its Lock_I is seen low.
    logic [NUM_REQ-1:0]   relock_blk_q;
    logic [NUM_REQ-1:0]   tag_q [READ_LATENCY];

    logic [NUM_REQ-1:0]   gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic [ADDR_W-1:0]    addr_mux;
    int                   cand;

    // Wrap-around increment of a requester index.
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant selection: owner-exclusive while locked, otherwise first requester at or after rr_ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        if (state_q == LOCKED) begin
            if (Req_En_I[owner_q]) begin
                gnt[owner_q] = 1'b1;
                gnt_idx      = owner_q;
                gnt_any      = 1'b1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!gnt_any && Req_En_I[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = PTR_W'(cand);
                    gnt_any   = 1'b1;
                end
            end
        end
    end

    // ROM address mux driven by the one-hot grant; zero when idle.
    always_comb begin
        addr_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                addr_mux = Req_Addr_I[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Lock FSM, round-robin pointer, lock counter and registered timeout pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= UNLOCKED;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            relock_blk_q <= '0;
        end else begin
            timeout_q    <= 1'b0;
            relock_blk_q <= relock_blk_q & Lock_I;
            case (state_q)
                UNLOCKED: begin
                    if (gnt_any) begin
                        rr_ptr_q <= inc_ptr(gnt_idx);
                        if (Lock_I[gnt_idx] && !relock_blk_q[gnt_idx]) begin
                            state_q    <= LOCKED;
                            owner_q    <= gnt_idx;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (gnt_any) begin
                        rr_ptr_q <= inc_ptr(owner_q);
                    end
                    // A voluntary release wins over a coincident timeout.
                    if (!Lock_I[owner_q]) begin
                        state_q  <= UNLOCKED;
                        rr_ptr_q <= inc_ptr(owner_q);
                    end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                        state_q               <= UNLOCKED;
                        rr_ptr_q              <= inc_ptr(owner_q);
                        timeout_q             <= 1'b1;
                        relock_blk_q[owner_q] <= 1'b1;
                    end else if (lock_cnt_q != CNT_W'(LOCK_MAX)) begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    // Tag pipeline: the one-hot grant travels alongside the ROM read latency.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign Grant_O        = gnt;
    assign Table_En_O     = gnt_any;
    assign Table_Addr_O   = addr_mux;
    assign Data_Valid_O   = tag_q[READ_LATENCY-1];
    assign Data_O         = Table_Data_I;
    assign Lock_Timeout_O = timeout_q;

endmodule

// File: doc/coeff_table_arbiter.md
Name: coeff_table_arbiter

Overview:
- Shares the single-port coefficient/VLC lookup table ROM between the slice-level decoders: motion vector decode, DCT coefficient decode and macroblock address/type decode.
- Arbitrates per-cycle lookup requests with round-robin priority.
- Supports a lock so that one decoder can run a multi-lookup VLC walk uninterrupted.
- Returns ROM data with a per-requester valid strobe aligned to the ROM read latency.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = vector decode, 1 = coefficient decode, 2 = macroblock decode.
- ADDR_W, 10, table address width.
- DATA_W, 16, table data width.
- READ_LATENCY, 1, ROM cycles from En to data, legal range 1..4.
- LOCK_MAX, 64, maximum consecutive cycles a lock may be held before forced release.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset; active low, asynchronous.
- Req_En_I  in  NUM_REQ  per-requester lookup request.
- Req_Addr_I  in  NUM_REQ*ADDR_W  per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- Lock_I  in  NUM_REQ  per-requester lock request; meaningful only while that requester holds the grant.
- Grant_O  out  NUM_REQ  one-hot; combinational; asserted in the cycle the request is issued to the ROM.
- Data_Valid_O  out  NUM_REQ  one-hot; Data_O belongs to this requester in this cycle.
- Data_O  out  DATA_W  ROM read data (pass-through of Table_Data_I).
- Lock_Timeout_O  out  1  one-cycle pulse when a lock is forcibly released.
- Table_En_O  out  1  ROM read enable.
- Table_Addr_O  out  ADDR_W  ROM address.
- Table_Data_I  in  DATA_W  ROM read data.

Behaviour:
- Reset values: rr_ptr = 0 (requester 0 highest priority); lock_owner invalid; lock_cnt = 0; tag pipeline all zero; Grant_O = 0; Data_Valid_O = 0; Lock_Timeout_O = 0; Table_En_O = 0; Table_Addr_O = 0.
- Reset mid-operation: in-flight tags are discarded, no Data_Valid_O is produced, and any lock is dropped.
- Round-robin selection, unlocked: search starts at rr_ptr and wraps modulo NUM_REQ; the first i with Req_En_I[i]=1 is granted.
  - Grant_O[i]=1, Table_En_O=1, Table_Addr_O = Req_Addr_I[i], all in the same cycle.
  - On a grant, rr_ptr <= (i+1) mod NUM_REQ at the clock edge. With no request, rr_ptr holds.
- Handshake: the request is consumed in any cycle where Grant_O[i]=1. A requester not granted must hold Req_En_I and its address stable. Back-to-back requests from the same requester are allowed.
- Tag pipeline:
  - READ_LATENCY-deep shift register of the one-hot Grant_O vector.
  - Data_Valid_O = stage[READ_LATENCY-1].
  - Data_Valid_O[i] rises exactly READ_LATENCY cycles after Grant_O[i].
  - Throughput: one lookup per cycle.
- Lock FSM states: UNLOCKED, LOCKED.
  - UNLOCKED -> LOCKED at the clock edge of a cycle in which Grant_O[i]=1 and Lock_I[i]=1. lock_owner <= i, lock_cnt <= 0.
  - In LOCKED, only lock_owner may be granted; other requests stall. The owner may idle: no request gives Table_En_O=0 and the lock is kept. lock_cnt increments every LOCKED cycle and saturates at LOCK_MAX.
  - LOCKED -> UNLOCKED when Lock_I[owner]=0. That cycle is still owner-exclusive, and the owner's request in that cycle is granted.
  - LOCKED -> UNLOCKED also when lock_cnt reaches LOCK_MAX-1. Lock_Timeout_O pulses for 1 cycle, and rr_ptr <= (owner+1) mod NUM_REQ.
  - On normal unlock, rr_ptr <= (owner+1) mod NUM_REQ. The owner is then lowest priority next cycle.
  - After a timeout, the timed-out owner cannot re-lock until Lock_I[owner] has been seen low for at least 1 cycle. Its ordinary requests are still served.
- Simultaneous events: a request and a lock in the same cycle from different requesters is resolved purely by round-robin. Lock_I from a non-granted requester is ignored.
- No combinational path from Table_Data_I to any output other than Data_O.

Test Plan:
- Reset; Req_En_I=3'b111 held 6 cycles, addresses 0x010/0x020/0x030 -> grants 0,1,2,0,1,2. Table_Addr_O follows the same order. With READ_LATENCY=1, Data_Valid_O follows each grant one cycle later with matching Data_O.
- READ_LATENCY=3, single requester 1 issues 4 back-to-back lookups -> Table_En_O high for 4 cycles, then Data_Valid_O=3'b010 for 4 cycles starting 3 cycles after the first grant.
- Requester 0 granted with Lock_I[0]=1 for 5 cycles while Req_En_I[2]=1 -> Grant_O[2] stays 0 throughout. Lock_I[0] drops -> Grant_O[2]=1 on the following cycle.
- LOCK_MAX=8, requester 1 holds Lock_I high indefinitely -> Lock_Timeout_O pulses once, 8 cycles after lock entry. A pending requester 2 is granted the next cycle, and requester 1 does not re-lock while Lock_I[1] stays high.
- Assert resetn=0 with 2 lookups in flight (READ_LATENCY=2) -> no Data_Valid_O pulses appear after reset release. Grant order then restarts at requester 0.
- Single requester 0 with no contention -> granted every cycle with zero stall. rr_ptr rotation does not starve or delay it.
